// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD <-> binary converters on the ALU display path.
package bcd_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned N_DIGITS    = 3;
  localparam int unsigned BCD_W       = DIGIT_W * N_DIGITS;
  localparam int unsigned OUT_W       = 10;
  localparam int unsigned LIMIT       = 255;
  localparam int unsigned SHIFT_COUNT = OUT_W;
  localparam int unsigned CNT_W       = $clog2(SHIFT_COUNT + 1);

  // Two-state control; kept as plain constants so older tools read it unchanged.
  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t SHIFT = 1'b1;

  typedef struct packed {
    logic [DIGIT_W-1:0] cientos;
    logic [DIGIT_W-1:0] dieces;
    logic [DIGIT_W-1:0] unos;
  } bcd_word_t;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(9);
  endfunction

  function automatic logic word_ok(input bcd_word_t w);
    return digit_ok(w.cientos) && digit_ok(w.dieces) && digit_ok(w.unos);
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when the digit is 8 or more.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= DIGIT_W'(8)) begin
      digit_o = digit_i - DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential 3-digit BCD to binary converter: one shift-and-correct step per clock,
// start/ready handshake, flags for invalid digits and results above LIMIT.
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int unsigned OUT_W = bcd_pkg::OUT_W,
  parameter int unsigned LIMIT = bcd_pkg::LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [3:0]       cientos,
  input  logic [3:0]       dieces,
  input  logic [3:0]       unos,
  output logic [OUT_W-1:0] binario,
  output logic             ocupado,
  output logic             listo,
  output logic             error_bcd,
  output logic             fuera_rango
);

  localparam int unsigned TOT_W = BCD_W + OUT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [OUT_W-1:0] bin_q, bin_d;
  logic [OUT_W-1:0] binario_q, binario_d;
  logic             ocupado_q, ocupado_d;
  logic             listo_q, listo_d;
  logic             error_q, error_d;
  logic             fuera_q, fuera_d;

  bcd_word_t        din_c;
  logic [TOT_W-1:0] shifted_c;
  logic [BCD_W-1:0] sh_bcd_c;
  logic [OUT_W-1:0] sh_bin_c;
  logic [BCD_W-1:0] adj_bcd_c;

  assign din_c     = {cientos, dieces, unos};
  assign shifted_c = {bcd_q, bin_q} >> 1;
  assign sh_bcd_c  = shifted_c[TOT_W-1:OUT_W];
  assign sh_bin_c  = shifted_c[OUT_W-1:0];

  // Correct each digit after the shift so the next shift divides it cleanly by two.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (sh_bcd_c[g*DIGIT_W +: DIGIT_W]),
      .digit_o (adj_bcd_c[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    binario_d = binario_q;
    ocupado_d = ocupado_q;
    listo_d   = 1'b0;
    error_d   = error_q;
    fuera_d   = fuera_q;

    case (state_q)
      IDLE: begin
        if (inicio) begin
          if (word_ok(din_c)) begin
            bcd_d     = din_c;
            bin_d     = '0;
            error_d   = 1'b0;
            fuera_d   = 1'b0;
            cnt_d     = '0;
            ocupado_d = 1'b1;
            state_d   = SHIFT;
          end else begin
            // Rejected request completes immediately with the error flag set.
            binario_d = '0;
            error_d   = 1'b1;
            fuera_d   = 1'b0;
            listo_d   = 1'b1;
          end
        end
      end

      SHIFT: begin
        bcd_d = adj_bcd_c;
        bin_d = sh_bin_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          binario_d = sh_bin_c;
          fuera_d   = (sh_bin_c > OUT_W'(LIMIT));
          listo_d   = 1'b1;
          ocupado_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        ocupado_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bcd_q     <= '0;
      bin_q     <= '0;
      binario_q <= '0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
      error_q   <= 1'b0;
      fuera_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      binario_q <= binario_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
      error_q   <= error_d;
      fuera_q   <= fuera_d;
    end
  end

  assign binario     = binario_q;
  assign ocupado     = ocupado_q;
  assign listo       = listo_q;
  assign error_bcd   = error_q;
  assign fuera_rango = fuera_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed handshake cases, random digits and a
// 0..255 round trip, all checked against an arithmetic reference.
module tb_bcd_to_binary;

  logic       clk = 1'b0;
  logic       rst;
  logic       inicio;
  logic [3:0] cientos, dieces, unos;
  logic [9:0] binario;
  logic       ocupado, listo, error_bcd, fuera_rango;

  int checks = 0;
  int errors = 0;

  bcd_to_binary dut (
    .clk         (clk),
    .rst         (rst),
    .inicio      (inicio),
    .cientos     (cientos),
    .dieces      (dieces),
    .unos        (unos),
    .binario     (binario),
    .ocupado     (ocupado),
    .listo       (listo),
    .error_bcd   (error_bcd),
    .fuera_rango (fuera_rango)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one request and check its whole handshake; returns right after the listo cycle is seen.
  task automatic conv(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                      input string tag);
    int  v;
    int  k;
    int  busy;
    bit  valid;
    valid = (c <= 9) && (d <= 9) && (u <= 9);
    v     = int'(c) * 100 + int'(d) * 10 + int'(u);
    cientos = c; dieces = d; unos = u;
    inicio  = 1'b1;
    step();
    inicio  = 1'b0;
    // Digit inputs after the accepting edge must not matter.
    cientos = 4'($urandom); dieces = 4'($urandom); unos = 4'($urandom);
    if (!valid) begin
      check({tag, "_err_listo"}, 32'(listo), 32'd1);
      check({tag, "_err_flag"},  32'(error_bcd), 32'd1);
      check({tag, "_err_bin"},   32'(binario), 32'd0);
      check({tag, "_err_fuera"}, 32'(fuera_rango), 32'd0);
      check({tag, "_err_busy"},  32'(ocupado), 32'd0);
    end else begin
      busy = ocupado ? 1 : 0;
      k = 0;
      while (!listo && k < 30) begin
        step();
        k++;
        if (!listo && ocupado) busy++;
      end
      check({tag, "_latency"}, 32'(k), 32'd10);
      check({tag, "_busy"},    32'(busy), 32'd10);
      check({tag, "_listo"},   32'(listo), 32'd1);
      check({tag, "_bin"},     32'(binario), 32'(v));
      check({tag, "_fuera"},   32'(fuera_rango), 32'(v > 255));
      check({tag, "_err"},     32'(error_bcd), 32'd0);
      check({tag, "_done_busy"}, 32'(ocupado), 32'd0);
    end
  endtask

  initial begin
    int k;
    int v;
    bit seen;
    rst = 1'b1; inicio = 1'b0; cientos = '0; dieces = '0; unos = '0;
    step(); step();
    check("rst_bin",   32'(binario), 32'd0);
    check("rst_busy",  32'(ocupado), 32'd0);
    check("rst_listo", 32'(listo), 32'd0);
    check("rst_err",   32'(error_bcd), 32'd0);
    check("rst_fuera", 32'(fuera_rango), 32'd0);
    rst = 1'b0;
    step();

    conv(4'd2, 4'd5, 4'd5, "c255");
    step();
    check("c255_listo_drop", 32'(listo), 32'd0);

    conv(4'd9, 4'd9, 4'd9, "c999");
    step();

    // Second start issued during the listo cycle must be accepted.
    conv(4'd0, 4'd0, 4'd0, "c000");
    conv(4'd1, 4'd2, 4'd8, "c128");
    step();

    conv(4'd3, 4'hA, 4'd1, "bad_d");
    step();
    check("bad_listo_drop", 32'(listo), 32'd0);
    check("bad_busy_after", 32'(ocupado), 32'd0);

    // A request while busy is ignored.
    cientos = 4'd1; dieces = 4'd0; unos = 4'd0; inicio = 1'b1;
    step();
    inicio = 1'b0;
    step(); step(); step();
    cientos = 4'd3; dieces = 4'd3; unos = 4'd3; inicio = 1'b1;
    step();
    inicio = 1'b0;
    k = 4;
    while (!listo && k < 30) begin step(); k++; end
    check("ign_latency", 32'(k), 32'd10);
    check("ign_bin", 32'(binario), 32'd100);
    step();
    check("ign_no_second", 32'(ocupado), 32'd0);

    // Asynchronous reset mid-conversion.
    cientos = 4'd2; dieces = 4'd0; unos = 4'd0; inicio = 1'b1;
    step();
    inicio = 1'b0;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    check("arst_bin",   32'(binario), 32'd0);
    check("arst_busy",  32'(ocupado), 32'd0);
    check("arst_listo", 32'(listo), 32'd0);
    check("arst_err",   32'(error_bcd), 32'd0);
    check("arst_fuera", 32'(fuera_rango), 32'd0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (listo || ocupado) seen = 1'b1;
    end
    check("arst_no_listo", 32'(seen), 32'd0);

    // Random digits, roughly one in five requests carrying an invalid digit.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] c, d, u;
      c = 4'($urandom_range(9)); d = 4'($urandom_range(9)); u = 4'($urandom_range(9));
      if ($urandom_range(4) == 0) begin
        case ($urandom_range(2))
          0: c = 4'($urandom_range(15, 10));
          1: d = 4'($urandom_range(15, 10));
          default: u = 4'($urandom_range(15, 10));
        endcase
      end
      conv(c, d, u, "rnd");
      if ($urandom_range(1) == 0) step();
    end
    step();

    // Round trip: digits of every 8-bit value, as the binary-to-BCD converter would produce them.
    for (int val = 0; val < 256; val++) begin
      v = val;
      conv(4'(v / 100), 4'((v / 10) % 10), 4'(v % 10), "rt");
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
Sequential converter from 3-digit packed BCD (cientos/dieces/unos) to unsigned binary. It performs the inverse of the team's binary-to-BCD converter, using reverse double-dabble: one shift-and-correct step per clock. It sits on the ALU result/display path where keypad or display digits must return to binary operands. A start/ready handshake lets a controller launch one conversion at a time and flags invalid digits and values above 8-bit range.

Parameters:
- OUT_W, 10, result width; fixed to ceil(log2(1000)) = 10. Also sets the shift count.
- LIMIT, 255, threshold for fuera_rango (the maximum 8-bit operand).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- inicio  input  1  start request; sampled only in IDLE
- cientos  input  4  hundreds BCD digit
- dieces  input  4  tens BCD digit
- unos  input  4  units BCD digit
- binario  output  OUT_W  converted result; held until the next accepted start
- ocupado  output  1  conversion in progress
- listo  output  1  one-cycle completion pulse
- error_bcd  output  1  an input digit was >9; held until the next accepted start
- fuera_rango  output  1  binario > LIMIT; held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: binario=0, ocupado=0, listo=0, error_bcd=0, fuera_rango=0, state=IDLE, counter=0.
- Reset asserted mid-conversion clears everything immediately. No listo pulse is produced for the aborted conversion.
- States:
  - IDLE and SHIFT are the only states.
  - listo, binario and the flags are registered.
- IDLE, inicio=1 at edge N, all digits ≤9:
  - Load the 12-bit BCD register {cientos,dieces,unos}.
  - Clear the OUT_W-bit shift register, clear error_bcd and fuera_rango.
  - Set counter=0, ocupado=1, go to SHIFT.
- IDLE, inicio=1 at edge N, any digit >9:
  - No conversion. At edge N: binario=0, error_bcd=1, fuera_rango=0, listo=1 for one cycle.
  - ocupado stays 0; state stays IDLE.
- SHIFT, each edge:
  - Shift the concatenation {bcd, bin} right by 1. The BCD LSB enters the bin MSB; the BCD MSB fills with 0.
  - Then each 4-bit BCD digit ≥8 has 3 subtracted.
  - counter increments.
- Termination: at the edge performing shift number OUT_W (edge N+10):
  - binario is loaded with the final shift result.
  - fuera_rango = (result > LIMIT).
  - listo=1, ocupado=0, return to IDLE.
- Latency: start accepted at edge N, result and listo visible after edge N+10. listo is high for exactly one cycle.
- listo drop: listo returns to 0 on the next edge unless another invalid start occurs there.
- inicio while ocupado=1: ignored and not queued.
- Back-to-back: inicio high in the cycle listo is high is accepted, because the state is already IDLE.
- Input stability: digit inputs are sampled only at the accepting edge. Changes during SHIFT have no effect.
- Arithmetic: all unsigned. The maximum input 999 gives 10'h3E7, so there is no overflow in OUT_W.

Decomposition:
- Shared package bcd_pkg:
  - DIGIT_W=4, N_DIGITS=3, OUT_W=10, LIMIT=255, SHIFT_COUNT=OUT_W.
  - State encoding typedef with IDLE and SHIFT.
  - Both this block and the binary-to-BCD converter import it.
- One sub-module: bcd_digit_adjust.
  - Combinational, 4-bit in, 4-bit out: out = (in ≥ 8) ? in−3 : in.
  - Instantiated three times.

Test Plan:
- Digits 2,5,5, pulse inicio:
  - ocupado high for 10 cycles, then listo pulses one cycle.
  - binario=255, fuera_rango=0, error_bcd=0.
- Digits 9,9,9: binario=999 (10'h3E7), fuera_rango=1, listo after 10 shifts.
- Digits 0,0,0 then 1,2,8:
  - binario=0, then 128; flags 0.
  - Second start is issued in the listo cycle and must be accepted.
- Digit dieces=4'hA: at the next edge listo=1, error_bcd=1, binario=0, ocupado never asserted.
- Start 1,0,0; assert inicio again with 3,3,3 at cycle 4:
  - The second request is ignored; binario=100.
  - Then rst pulse mid-conversion: all outputs are 0 asynchronously and no listo follows.
- Round trip: for all values 0..255, feed the existing binary-to-BCD converter's outputs into this block. Required: binario equals the original value, and fuera_rango=0 for every value.
